// File: rtl/mips_pkg.sv
// Shared encodings for the EX stage: ALU ops, multiply/divide ops, forwarding selects
// and the multiply/divide FSM states.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_AND      = 4'd2,
        ALU_OR       = 4'd3,
        ALU_XOR      = 4'd4,
        ALU_NOR      = 4'd5,
        ALU_SLT      = 4'd6,
        ALU_SLTU     = 4'd7,
        ALU_SLL      = 4'd8,
        ALU_SRL      = 4'd9,
        ALU_SRA      = 4'd10,
        ALU_LUI      = 4'd11,
        ALU_MFHI     = 4'd12,
        ALU_MFLO     = 4'd13,
        ALU_MD_START = 4'd14,
        ALU_RSVD     = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_WB    = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Magnitude of a 32-bit operand; unsigned ops pass through untouched.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, signs applied in FIX.
//   state   | meaning
//   IDLE    | waiting for start; HI/LO hold last result
//   MUL     | shift-add, one multiplier bit per cycle
//   DIV     | restoring divide, one quotient bit per cycle
//   FIX     | apply signs / divide-by-zero rule, write HI/LO
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      op,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;       // product, or {remainder, quotient}
    logic [31:0]      mcand;     // multiplicand or divisor magnitude
    logic [31:0]      a_raw, b_raw;
    md_op_e           op_q;
    logic             is_mul, sgn, neg_a, neg_b;
    logic [32:0]      mul_sum;
    logic [32:0]      div_shift;
    logic [33:0]      div_diff;
    logic [31:0]      hi_fix, lo_fix;

    assign busy    = (state != ST_IDLE);
    assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = is_mul ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_comb begin
        sgn    = (op_q == MD_MULT) || (op_q == MD_DIV);
        neg_a  = sgn & a_raw[31];
        neg_b  = sgn & b_raw[31];
        hi_fix = acc[63:32];
        lo_fix = acc[31:0];
        if ((op_q == MD_MULT) || (op_q == MD_MULTU)) begin
            if (neg_a ^ neg_b) {hi_fix, lo_fix} = ~acc + 64'd1;
        end else if (b_raw == '0) begin
            lo_fix = '1;
            hi_fix = a_raw;
        end else begin
            if (neg_a ^ neg_b) lo_fix = ~acc[31:0] + 32'd1;
            // remainder takes the dividend's sign
            if (neg_a) hi_fix = ~acc[63:32] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            a_raw <= '0;
            b_raw <= '0;
            op_q  <= MD_MULT;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        a_raw <= a;
                        b_raw <= b;
                        op_q  <= op;
                        cnt   <= CNT_W'(MD_CYCLES - 1);
                        if (is_mul) begin
                            acc   <= {32'd0, mag32(b, op == MD_MULT)};
                            mcand <= mag32(a, op == MD_MULT);
                        end else begin
                            acc   <= {32'd0, mag32(a, op == MD_DIV)};
                            mcand <= mag32(b, op == MD_DIV);
                        end
                    end
                end
                ST_MUL: begin
                    acc <= {mul_sum, acc[31:1]};
                    cnt <= cnt - 1'b1;
                end
                ST_DIV: begin
                    if (div_diff[33]) acc <= {div_shift[31:0], acc[30:0], 1'b0};
                    else              acc <= {div_diff[31:0],  acc[30:0], 1'b1};
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (!abort) begin
                        hi <= hi_fix;
                        lo <= lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Define EX_MULDIV_EN to include the iterative multiply/divide unit with HI/LO.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_alu_src,
    input  logic [1:0]        i_ForwardA,
    input  logic [1:0]        i_ForwardB,
    input  logic [DATA_W-1:0] i_fwd_exmem,
    input  logic [DATA_W-1:0] i_fwd_memwb,
    input  logic [DATA_W-1:0] i_fwd_wb,
    input  logic [3:0]        i_alu_op,
    input  logic [1:0]        i_md_op,
    input  logic [4:0]        i_shamt,
    input  logic [4:0]        i_rd,
    input  logic              i_regWrite,
    input  logic              i_memRead,
    input  logic              i_memWrite,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_store_data,
    output logic [4:0]        o_rd,
    output logic              o_regWrite,
    output logic              o_memRead,
    output logic              o_memWrite,
    output logic              o_stall,
    output logic              o_md_busy
);

    alu_op_e           op;
    logic [DATA_W-1:0] opa, opb_fwd, opb, alu_res;
    logic [DATA_W-1:0] hi, lo;
    logic              md_sel, bubble, wr_kill;

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] rf);
        case (fwd_sel_e'(sel))
            FWD_EXMEM: return i_fwd_exmem;
            FWD_MEMWB: return i_fwd_memwb;
            FWD_WB:    return i_fwd_wb;
            default:   return rf;
        endcase
    endfunction

    assign op      = alu_op_e'(i_alu_op);
    assign opa     = fwd_mux(i_ForwardA, i_rs_data);
    assign opb_fwd = fwd_mux(i_ForwardB, i_rt_data);
    assign opb     = i_alu_src ? i_imm : opb_fwd;
    assign md_sel  = (op == ALU_MFHI) || (op == ALU_MFLO) || (op == ALU_MD_START);

`ifdef EX_MULDIV_EN
    logic md_start;

    // a killed instruction may neither start nor stall
    assign o_stall  = md_sel && o_md_busy && !i_flush;
    assign md_start = (op == ALU_MD_START) && !o_md_busy && !i_flush;
    assign bubble   = i_flush || o_stall || (op == ALU_MD_START);
    assign wr_kill  = 1'b0;

    ex_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .a     (opa),
        .b     (opb),
        .op    (md_op_e'(i_md_op)),
        .start (md_start),
        .abort (i_flush),
        .busy  (o_md_busy),
        .hi    (hi),
        .lo    (lo)
    );
`else
    logic unused_md;

    assign unused_md = ^i_md_op;
    assign o_stall   = 1'b0;
    assign o_md_busy = 1'b0;
    assign hi        = '0;
    assign lo        = '0;
    assign bubble    = i_flush;
    assign wr_kill   = md_sel;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_NOR:  alu_res = ~(opa | opb);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
            ALU_SLL:  alu_res = opb << i_shamt;
            ALU_SRL:  alu_res = opb >> i_shamt;
            ALU_SRA:  alu_res = DATA_W'($signed(opb) >>> i_shamt);
            ALU_LUI:  alu_res = opb << 16;
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result     <= '0;
            o_store_data <= '0;
            o_rd         <= '0;
            o_regWrite   <= 1'b0;
            o_memRead    <= 1'b0;
            o_memWrite   <= 1'b0;
        end else if (bubble) begin
            o_result     <= '0;
            o_store_data <= '0;
            o_rd         <= '0;
            o_regWrite   <= 1'b0;
            o_memRead    <= 1'b0;
            o_memWrite   <= 1'b0;
        end else begin
            o_result     <= alu_res;
            o_store_data <= opb_fwd;
            o_rd         <= i_rd;
            o_regWrite   <= i_regWrite && !wr_kill;
            o_memRead    <= i_memRead;
            o_memWrite   <= i_memWrite;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiply/divide checks run when EX_MULDIV_EN is defined.
module tb_ex_stage;
    import mips_pkg::*;

    logic        i_clk, i_rst_n;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic        i_alu_src;
    logic [1:0]  i_ForwardA, i_ForwardB;
    logic [31:0] i_fwd_exmem, i_fwd_memwb, i_fwd_wb;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_md_op;
    logic [4:0]  i_shamt, i_rd;
    logic        i_regWrite, i_memRead, i_memWrite, i_flush;
    logic [31:0] o_result, o_store_data;
    logic [4:0]  o_rd;
    logic        o_regWrite, o_memRead, o_memWrite, o_stall, o_md_busy;

    int n_checks = 0;
    int n_pass   = 0;

    ex_stage #(.DATA_W(32), .MD_CYCLES(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_alu_src(i_alu_src), .i_ForwardA(i_ForwardA), .i_ForwardB(i_ForwardB),
        .i_fwd_exmem(i_fwd_exmem), .i_fwd_memwb(i_fwd_memwb), .i_fwd_wb(i_fwd_wb),
        .i_alu_op(i_alu_op), .i_md_op(i_md_op), .i_shamt(i_shamt), .i_rd(i_rd),
        .i_regWrite(i_regWrite), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_flush(i_flush),
        .o_result(o_result), .o_store_data(o_store_data), .o_rd(o_rd),
        .o_regWrite(o_regWrite), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
        .o_stall(o_stall), .o_md_busy(o_md_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_defaults();
        i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_alu_src = 1'b0;
        i_ForwardA = 2'd0; i_ForwardB = 2'd0;
        i_fwd_exmem = '0; i_fwd_memwb = '0; i_fwd_wb = '0;
        i_alu_op = ALU_ADD; i_md_op = MD_MULT; i_shamt = '0; i_rd = '0;
        i_regWrite = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_flush = 1'b0;
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        set_defaults();
        i_alu_op = op; i_rs_data = a; i_rt_data = b; i_shamt = sh;
        i_rd = 5'd9; i_regWrite = 1'b1;
        step();
        chk(tag, o_result, exp);
    endtask

`ifdef EX_MULDIV_EN
    task automatic md_go(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        set_defaults();
        i_alu_op = ALU_MD_START; i_md_op = mop; i_rs_data = a; i_rt_data = b;
        i_rd = 5'd4; i_regWrite = 1'b1;
        #1;
        chk("md_start no stall", o_stall, 0);
        step();
        chk("md_start bubble", o_regWrite, 0);
        chk("md_start busy", o_md_busy, 1);
    endtask

    task automatic read_md(input string tag, input logic [3:0] op, input logic [31:0] exp);
        int guard = 0;
        set_defaults();
        i_alu_op = op; i_rd = 5'd3; i_regWrite = 1'b1;
        #1;
        while (o_stall && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, " wait"}, 32'(guard < 100), 1);
        step();
        chk(tag, o_result, exp);
        chk({tag, " wr"}, o_regWrite, 1);
    endtask
`endif

    initial begin
        set_defaults();
        i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst result", o_result, 0);
        chk("rst rd", o_rd, 0);
        chk("rst regwrite", o_regWrite, 0);
        chk("rst stall", o_stall, 0);
        chk("rst busy", o_md_busy, 0);
        step();
        step();
        i_rst_n = 1'b1;

        // forwarded A plus register B
        set_defaults();
        i_ForwardA = 2'd1; i_fwd_exmem = 32'd5; i_rs_data = 32'd100; i_rt_data = 32'd3;
        i_rd = 5'd7; i_regWrite = 1'b1;
        step();
        chk("fwd exmem add", o_result, 32'd8);
        chk("fwd rd", o_rd, 7);
        chk("fwd regwrite", o_regWrite, 1);

        alu_chk("sub neg",  ALU_SUB,  32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE);
        alu_chk("add wrap", ALU_ADD,  32'hFFFF_FFFF,  32'd2,          5'd0,  32'd1);
        alu_chk("and",      ALU_AND,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'h00F0_000F);
        alu_chk("or",       ALU_OR,   32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'hFFF0_0FFF);
        alu_chk("xor",      ALU_XOR,  32'hF0F0_00FF,  32'h0FF0_0F0F,  5'd0,  32'hFF00_0FF0);
        alu_chk("nor",      ALU_NOR,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF);
        alu_chk("slt",      ALU_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1);
        alu_chk("sltu",     ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0);
        alu_chk("sll 31",   ALU_SLL,  32'd0,          32'd1,          5'd31, 32'h8000_0000);
        alu_chk("srl",      ALU_SRL,  32'd0,          32'h8000_0000,  5'd4,  32'h0800_0000);
        alu_chk("sra",      ALU_SRA,  32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000);
        alu_chk("reserved", ALU_RSVD, 32'd7,          32'd9,          5'd0,  32'd0);

        // LUI on immediate; store data is the forwarded B before the immediate mux
        set_defaults();
        i_alu_op = ALU_LUI; i_alu_src = 1'b1; i_imm = 32'h0000_1234;
        i_rt_data = 32'hAAAA_5555; i_memWrite = 1'b1; i_memRead = 1'b1;
        step();
        chk("lui", o_result, 32'h1234_0000);
        chk("lui store", o_store_data, 32'hAAAA_5555);
        chk("memwrite", o_memWrite, 1);
        chk("memread", o_memRead, 1);

        set_defaults();
        i_alu_op = ALU_SUB; i_ForwardA = 2'd3; i_fwd_wb = 32'h20;
        i_ForwardB = 2'd2; i_fwd_memwb = 32'h10; i_rt_data = 32'h99; i_regWrite = 1'b1;
        step();
        chk("fwd wb-memwb sub", o_result, 32'h10);
        chk("fwd store", o_store_data, 32'h10);

        set_defaults();
        i_alu_op = ALU_ADD; i_rs_data = 32'd1; i_rt_data = 32'd2;
        i_rd = 5'd12; i_regWrite = 1'b1; i_memRead = 1'b1; i_flush = 1'b1;
        step();
        chk("flush regwrite", o_regWrite, 0);
        chk("flush rd", o_rd, 0);
        chk("flush memread", o_memRead, 0);
        chk("flush result", o_result, 0);

`ifdef EX_MULDIV_EN
        md_go(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        begin
            int stalls = 0;
            int bad = 0;
            set_defaults();
            step();
            set_defaults();
            i_alu_op = ALU_MFLO; i_rd = 5'd3; i_regWrite = 1'b1;
            #1;
            while (o_stall && stalls < 100) begin
                step();
                if (o_regWrite !== 1'b0) bad++;
                stalls++;
            end
            chk("mflo stall cycles", stalls, 32);
            chk("stall bubbles", bad, 0);
            step();
            chk("mult lo", o_result, 32'hFFFF_FFEB);
        end
        read_md("mult hi", ALU_MFHI, 32'hFFFF_FFFF);

        md_go(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        read_md("div lo", ALU_MFLO, 32'hFFFF_FFFD);
        read_md("div hi", ALU_MFHI, 32'hFFFF_FFFF);

        md_go(MD_DIVU, 32'd5, 32'd0);
        read_md("divu0 lo", ALU_MFLO, 32'hFFFF_FFFF);
        read_md("divu0 hi", ALU_MFHI, 32'd5);

        // abort a divide part-way through
        md_go(MD_DIV, 32'd100, 32'd7);
        repeat (9) begin
            set_defaults();
            step();
        end
        set_defaults();
        i_flush = 1'b1; i_alu_op = ALU_ADD; i_rs_data = 32'd1; i_rd = 5'd7; i_regWrite = 1'b1;
        step();
        chk("abort busy", o_md_busy, 0);
        chk("abort bubble", o_regWrite, 0);
        chk("abort rd", o_rd, 0);
        read_md("abort hi kept", ALU_MFHI, 32'd5);
        read_md("abort lo kept", ALU_MFLO, 32'hFFFF_FFFF);

        // reset in the middle of a multiply
        md_go(MD_MULT, 32'd3, 32'd5);
        repeat (4) begin
            set_defaults();
            step();
        end
        set_defaults();
        i_alu_op = ALU_ADD; i_rs_data = 32'd6; i_rd = 5'd2; i_regWrite = 1'b1;
        step();
        i_alu_op = ALU_MFLO;
        #2 i_rst_n = 1'b0;
        #1;
        chk("midop rst busy", o_md_busy, 0);
        chk("midop rst stall", o_stall, 0);
        chk("midop rst result", o_result, 0);
        chk("midop rst rd", o_rd, 0);
        chk("midop rst regwrite", o_regWrite, 0);
        step();
        i_rst_n = 1'b1;
        alu_chk("sltu after rst", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd1);
        read_md("hi after rst", ALU_MFHI, 32'd0);
`else
        // without the multiply/divide unit ops 12-14 are harmless no-writes
        for (int k = 12; k <= 14; k++) begin
            set_defaults();
            i_alu_op = 4'(k); i_rs_data = 32'd9; i_rt_data = 32'd4;
            i_rd = 5'd6; i_regWrite = 1'b1;
            #1;
            chk($sformatf("op%0d stall", k), o_stall, 0);
            step();
            chk($sformatf("op%0d result", k), o_result, 0);
            chk($sformatf("op%0d regwrite", k), o_regWrite, 0);
            chk($sformatf("op%0d busy", k), o_md_busy, 0);
        end

        set_defaults();
        i_alu_op = ALU_ADD; i_rs_data = 32'd6; i_rt_data = 32'd1;
        i_rd = 5'd2; i_regWrite = 1'b1; i_memWrite = 1'b1;
        step();
        chk("pre-rst result", o_result, 32'd7);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async rst result", o_result, 0);
        chk("async rst store", o_store_data, 0);
        chk("async rst rd", o_rd, 0);
        chk("async rst regwrite", o_regWrite, 0);
        chk("async rst memwrite", o_memWrite, 0);
        step();
        i_rst_n = 1'b1;
        alu_chk("sltu after rst", ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
